if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
Parametrised instruction-fetch front end that replaces the single-cycle fetch path (pc register plus combinational ROM read). It issues word fetches to an instruction memory over a req/gnt/rvalid handshake, buffers up to DEPTH returned instructions with their addresses, and presents them in order to the IF/ID stage. It redirects on jump from ctrl, flushing the buffer and discarding stale in-flight responses, and stalls on hold without losing instructions.

Parameters:
XLEN, 32, instruction and address width
DEPTH, 4, prefetch buffer entries and maximum outstanding requests (power of two, >=2)
RESET_ADDR, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
jump_en_i  in  1  redirect request from ctrl
jump_addr_i  in  XLEN  redirect target; bits [1:0] ignored, treated as 0
hold_flag_i  in  1  consumer stall; head entry is not consumed
mem_req_o  out  1  fetch request valid
mem_addr_o  out  XLEN  fetch address, word aligned
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  in-order response valid
mem_rdata_i  in  XLEN  response instruction
inst_valid_o  out  1  head entry valid
inst_o  out  XLEN  head instruction; NOP 32'h0000_0013 when not valid
inst_addr_o  out  XLEN  head instruction address

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_ADDR, resp_pc=RESET_ADDR, occ=0, outstanding=0, drop=0, buffer empty. mem_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=RESET_ADDR. Reset mid-transaction abandons all in-flight requests; responses arriving after reset release while outstanding=0 are ignored.
- State: fetch_pc (next request address), resp_pc (address of next kept response), occ (0..DEPTH), outstanding (0..DEPTH, includes to-be-dropped), drop (0..outstanding).
- Request: mem_req_o = !jump_en_i && (occ + outstanding - drop < DEPTH) && (outstanding < DEPTH). mem_addr_o = fetch_pc. Grant = mem_req_o && mem_gnt_i: fetch_pc += 4, outstanding += 1. Uses registered counts; a pop in the same cycle does not free credit until the next cycle.
- Response: when mem_rvalid_i && outstanding>0: outstanding -= 1. If drop>0: drop -= 1 and data is discarded. Otherwise push {resp_pc, mem_rdata_i} and set resp_pc += 4. mem_rvalid_i with outstanding=0 is ignored. The credit rule guarantees a push never hits a full buffer.
- Pop: pop = inst_valid_o && !hold_flag_i && !jump_en_i. Push and pop in the same cycle leave occ unchanged.
- Latency: the buffer is registered with no bypass. A response pushed in cycle N appears on inst_* in cycle N+1. Gnt in cycle N with rvalid in N+1 gives inst_valid_o in N+2.
- Hold: inst_valid_o, inst_o and inst_addr_o are stable while hold_flag_i=1. Fetching continues until credit is exhausted.
- Jump (priority over hold, pop and push): buffer cleared (occ=0 next cycle), fetch_pc and resp_pc set to {jump_addr_i[XLEN-1:2],2'b00}, drop = outstanding - (mem_rvalid_i ? 1 : 0), and no request is issued in the jump cycle. The first target request can issue in the following cycle. A response in the jump cycle is discarded.
- Back-to-back jumps: each jump re-applies the flush. drop is recomputed from the current outstanding count, so no stale response is ever pushed.
- Wrap-around: fetch_pc and resp_pc wrap modulo 2^XLEN. Buffer pointers wrap modulo DEPTH.

Decomposition:
- Shared package rv_pkg: XLEN, INST_NOP=32'h0000_0013, RESET_ADDR default, and an inst_entry typedef {addr, inst}.
- Sub-module sync_fifo_flush: parametrised width/depth, registered output, synchronous flush input, and occ output. if_prefetch instantiates it with width 2*XLEN.

Test Plan:
- Reset, then mem_gnt_i=1 always and rvalid one cycle after grant with rdata=addr^32'hA5A5_A5A5, hold=0 -> requests 0x0,0x4,0x8,… on consecutive cycles, inst_valid_o first high 2 cycles after first grant, inst_addr_o increments by 4 each cycle, no gaps.
- hold_flag_i=1 for 10 cycles with the memory always granting -> at most DEPTH=4 requests accepted, then mem_req_o=0. Head stays at 0x0 during hold. On release, 0x0,0x4,0x8,0xC are delivered on consecutive cycles.
- Hold the response 3 cycles, then jump_en_i=1 with jump_addr_i=0x103 while 2 requests are outstanding -> buffer empty next cycle, both late responses discarded, next mem_addr_o=0x100, and first inst_addr_o=0x100.
- jump_en_i and mem_rvalid_i in the same cycle with outstanding=1 -> response discarded, drop=0, and target fetch proceeds normally.
- jump_en_i and hold_flag_i both high with 3 entries buffered -> flush wins and inst_valid_o=0 next cycle.
- Assert rst=0 mid-stream with 3 outstanding, release, then inject 3 spurious rvalids -> ignored, fetch restarts at RESET_ADDR, and inst_o=NOP until the first valid instruction.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, the NOP encoding,
// the default reset vector and the prefetch buffer entry layout.
package rv_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } inst_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with a registered storage array (no write-to-read bypass),
// a synchronous flush that takes priority over push/pop, and an occupancy count.
module sync_fifo_flush #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    occ
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];
  assign occ   = count;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues word fetches over req/gnt/rvalid, buffers
// returned instructions with their addresses and hands them to IF/ID in order.
module if_prefetch #(
  parameter int              XLEN       = rv_pkg::XLEN,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(rv_pkg::RESET_ADDR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_flag_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   jump_target;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;
  logic [CW:0]       in_use;
  logic              grant;
  logic              rsp;
  logic              keep;
  logic              pop;
  logic              buf_valid;
  logic [2*XLEN-1:0] head;

  assign jump_target = {jump_addr_i[XLEN-1:2], 2'b00};

  // Credit counts buffered entries plus live (non-dropped) requests, so every
  // kept response is guaranteed a free slot when it arrives.
  assign in_use    = {1'b0, occ} + {1'b0, outstanding} - {1'b0, drop};
  assign mem_req_o = rst && !jump_en_i && (in_use < {1'b0, DEPTH_C})
                     && (outstanding < DEPTH_C);
  assign mem_addr_o = fetch_pc;

  assign grant = mem_req_o && mem_gnt_i;
  assign rsp   = mem_rvalid_i && (outstanding != '0);
  assign keep  = rsp && (drop == '0) && !jump_en_i;
  assign pop   = buf_valid && !hold_flag_i && !jump_en_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (jump_en_i) begin
        fetch_pc <= jump_target;
        resp_pc  <= jump_target;
        drop     <= outstanding - CW'(rsp);
      end else begin
        if (grant)                 fetch_pc <= fetch_pc + XLEN'(4);
        if (keep)                  resp_pc  <= resp_pc + XLEN'(4);
        if (rsp && (drop != '0))   drop     <= drop - CW'(1);
      end
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
    end
  end

  sync_fifo_flush #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (jump_en_i),
    .push      (keep),
    .push_data ({resp_pc, mem_rdata_i}),
    .pop       (pop),
    .valid     (buf_valid),
    .head      (head),
    .occ       (occ)
  );

  // With an empty buffer the address output shows the next expected address.
  assign inst_valid_o = buf_valid;
  assign inst_o       = buf_valid ? head[XLEN-1:0] : XLEN'(rv_pkg::INST_NOP);
  assign inst_addr_o  = buf_valid ? head[2*XLEN-1:XLEN] : resp_pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: in-order memory model, a scoreboard of expected
// instructions, cycle vectors for streaming/hold, and jump/reset sequences.
module tb_if_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_q[$];
  bit          stale_q[$];
  logic [63:0] exp_q[$];
  bit          gnt_en;
  bit          rsp_en;
  bit          s_req;
  bit          s_valid;
  bit          s_grant;
  logic [31:0] s_addr;
  logic [31:0] s_iaddr;
  logic [31:0] s_inst;

  typedef struct {
    bit          first;
    bit          hold;
    bit          chk_req;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_iaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit keep_mem);
    rst          = 1'b0;
    jump_en_i    = 1'b0;
    jump_addr_i  = '0;
    hold_flag_i  = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    gnt_en       = 1'b0;
    rsp_en       = 1'b0;
    #1;
    check("reset_req",   32'(mem_req_o), 32'd0);
    check("reset_valid", 32'(inst_valid_o), 32'd0);
    check("reset_inst",  inst_o, NOP);
    check("reset_iaddr", inst_addr_o, 32'h0);
    if (keep_mem) begin
      foreach (stale_q[i]) stale_q[i] = 1'b1;
    end else begin
      mem_q.delete();
      stale_q.delete();
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: drive memory inputs, sample outputs, update scoreboard, advance.
  task automatic tick();
    logic [31:0] a;
    bit          s;
    logic [63:0] e;
    mem_gnt_i    = gnt_en;
    mem_rvalid_i = rsp_en && (mem_q.size() > 0);
    mem_rdata_i  = mem_rvalid_i ? (mem_q[0] ^ KEY) : 32'h0;
    #1;
    s_req   = mem_req_o;
    s_addr  = mem_addr_o;
    s_valid = inst_valid_o;
    s_iaddr = inst_addr_o;
    s_inst  = inst_o;
    s_grant = mem_req_o && mem_gnt_i;
    if (!s_valid) check("nop_idle", s_inst, NOP);
    if (s_valid && !hold_flag_i && !jump_en_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got addr %h, expected no instruction", s_iaddr);
      end else begin
        e = exp_q.pop_front();
        check("pop_addr", s_iaddr, e[63:32]);
        check("pop_inst", s_inst, e[31:0]);
      end
    end
    if (mem_rvalid_i) begin
      a = mem_q.pop_front();
      s = stale_q.pop_front();
      if (!s && !jump_en_i) exp_q.push_back({a, a ^ KEY});
    end
    if (jump_en_i) begin
      check("req_in_jump", 32'(s_req), 32'd0);
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      exp_q.delete();
    end
    if (s_grant) begin
      mem_q.push_back(s_addr);
      stale_q.push_back(1'b0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_first(input string name, input logic [31:0] exp_ia, input int max);
    bit          found = 1'b0;
    logic [31:0] ia = '0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      if (s_valid) begin
        found = 1'b1;
        ia    = s_iaddr;
      end
    end
    check({name, "_found"}, 32'(found), 32'd1);
    check(name, ia, exp_ia);
  endtask

  task automatic add_vec(input bit first, input bit hold, input bit chk_req, input bit exp_req,
                         input logic [31:0] exp_addr, input bit exp_valid,
                         input logic [31:0] exp_iaddr);
    vec_t v;
    v.first     = first;
    v.hold      = hold;
    v.chk_req   = chk_req;
    v.exp_req   = exp_req;
    v.exp_addr  = exp_addr;
    v.exp_valid = exp_valid;
    v.exp_iaddr = exp_iaddr;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    // Streaming from reset: back-to-back requests, 2-cycle latency, no gaps.
    for (int k = 0; k < 10; k++)
      add_vec(k == 0, 1'b0, 1'b1, 1'b1, 32'(4 * k), k >= 2, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
    // Hold for 10 cycles: exactly 4 requests, head pinned at 0x0, then drain.
    add_vec(1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0);
    for (int k = 4; k < 10; k++)
      add_vec(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00);
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04);
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08);
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10);

    rst = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].first) begin
        do_reset(1'b0);
        gnt_en = 1'b1;
        rsp_en = 1'b1;
      end
      hold_flag_i = vecs[i].hold;
      jump_en_i   = 1'b0;
      tick();
      if (vecs[i].chk_req) begin
        check("vec_req", 32'(s_req), 32'(vecs[i].exp_req));
        if (vecs[i].exp_req) check("vec_addr", s_addr, vecs[i].exp_addr);
      end
      check("vec_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check("vec_iaddr", s_iaddr, vecs[i].exp_iaddr);
    end

    // Jump with two responses held back: both late responses dropped.
    do_reset(1'b0);
    gnt_en = 1'b1;
    tick();
    tick();
    gnt_en = 1'b0;
    repeat (3) tick();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0103;
    gnt_en      = 1'b1;
    tick();
    jump_en_i = 1'b0;
    tick();
    check("jump_empty", 32'(s_valid), 32'd0);
    check("jump_req", 32'(s_req), 32'd1);
    check("jump_target_addr", s_addr, 32'h0000_0100);
    rsp_en = 1'b1;
    expect_first("jump_first", 32'h0000_0100, 10);

    // Jump coinciding with the only outstanding response.
    do_reset(1'b0);
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    tick();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0200;
    rsp_en      = 1'b1;
    tick();
    jump_en_i = 1'b0;
    gnt_en    = 1'b1;
    tick();
    check("jr_target_req", 32'(s_req), 32'd1);
    check("jr_target_addr", s_addr, 32'h0000_0200);
    tick();
    tick();
    check("jr_latency_valid", 32'(s_valid), 32'd1);
    check("jr_latency_addr", s_iaddr, 32'h0000_0200);

    // Jump and hold together with three entries buffered: flush wins.
    do_reset(1'b0);
    gnt_en      = 1'b1;
    rsp_en      = 1'b1;
    hold_flag_i = 1'b1;
    repeat (3) tick();
    gnt_en = 1'b0;
    tick();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0300;
    tick();
    check("pre_flush_valid", 32'(s_valid), 32'd1);
    check("pre_flush_head", s_iaddr, 32'h0);
    jump_en_i = 1'b0;
    tick();
    check("flush_wins", 32'(s_valid), 32'd0);
    hold_flag_i = 1'b0;
    gnt_en      = 1'b1;
    expect_first("flush_first", 32'h0000_0300, 8);

    // Reset with three requests in flight, then spurious responses.
    do_reset(1'b0);
    gnt_en = 1'b1;
    repeat (3) tick();
    do_reset(1'b1);
    rsp_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("spurious_ignored", 32'(s_valid), 32'd0);
    end
    gnt_en = 1'b1;
    tick();
    check("restart_req", 32'(s_req), 32'd1);
    check("restart_addr", s_addr, 32'h0);
    expect_first("restart_first", 32'h0, 6);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
